fetch_pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the IF stage's PC write enable (IFWrite) and redirect select (Branch/Jump qualification), the IF/ID register enable, and the ID/EX bubble insert. It arbitrates between boot hold, load-use hazards, control redirects, multi-cycle execute-unit busy and halt. It also keeps a stall-cycle performance counter.

---
 rtl/fetch_pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_fetch_pipe_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_pipe_ctrl.sv
// Pipeline stall/flush sequencer: boot hold, load-use stalls, redirects,
// multi-cycle execute wait and halt, plus a saturating stall-cycle counter.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   S_BOOT    | hold fetch while the instruction ROM settles
//   S_RUN     | normal issue; hazards/redirects resolved per cycle
//   S_MD_WAIT | fetch frozen until mul/div completes or times out
//   S_HALTED  | halt retired; left only through reset
module fetch_pipe_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int MD_TIMEOUT  = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             halt,
    output logic             IFWrite,
    output logic             Branch,
    output logic             Jump,
    output logic             IDWrite,
    output logic             ID_flush,
    output logic             IF_flush,
    output logic             busy,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_RUN     = 2'd1,
        S_MD_WAIT = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             md_err_q, md_err_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             hz;
    logic             stall_inc;

    assign hz = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        to_cnt_d   = to_cnt_q;
        md_err_d   = md_err_q;
        IFWrite    = 1'b0;
        IDWrite    = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        ID_flush   = 1'b1;
        busy       = 1'b1;
        case (state_q)
            S_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
                else boot_cnt_d = boot_cnt_q + 1'b1;
            end
            S_RUN: begin
                busy     = 1'b0;
                to_cnt_d = '0;
                if (hz) begin
                    // redirect/halt deliberately ignored; ID re-presents them
                end else if (halt) begin
                    state_d = S_HALTED;
                end else begin
                    IFWrite  = 1'b1;
                    IDWrite  = 1'b1;
                    ID_flush = 1'b0;
                    Branch   = branch_taken;
                    Jump     = jump && !branch_taken;
                end
                if (md_start) state_d = S_MD_WAIT;
            end
            S_MD_WAIT: begin
                ID_flush = 1'b0;
                if (md_done) begin
                    state_d  = S_RUN;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    md_err_d = 1'b1;
                    state_d  = S_RUN;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_HALTED: begin
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign IF_flush  = Branch | Jump;
    assign stall_inc = ((state_q == S_RUN) || (state_q == S_MD_WAIT)) && !IFWrite;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_BOOT;
            boot_cnt_q  <= '0;
            to_cnt_q    <= '0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            to_cnt_q   <= to_cnt_d;
            md_err_q   <= md_err_d;
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign md_err    = md_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed bench for fetch_pipe_ctrl: per-cycle expected outputs queued by the
// stimulus thread and checked by an independent negedge monitor.
module tb_fetch_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rt = 0, ex_memread = 0, branch_taken = 0, jump = 0;
    logic        md_start = 0, md_done = 0, halt = 0;
    logic        IFWrite, Branch, Jump, IDWrite, ID_flush, IF_flush, busy, md_err;
    logic [31:0] stall_cnt;

    fetch_pipe_ctrl #(.BOOT_CYCLES(4), .MD_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .branch_taken(branch_taken), .jump(jump), .md_start(md_start),
        .md_done(md_done), .halt(halt), .IFWrite(IFWrite), .Branch(Branch),
        .Jump(Jump), .IDWrite(IDWrite), .ID_flush(ID_flush), .IF_flush(IF_flush),
        .busy(busy), .md_err(md_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // flag order: {IFWrite, IDWrite, Branch, Jump, ID_flush, IF_flush, busy, md_err}
    localparam logic [7:0] F_RST   = 8'b0000_1010;
    localparam logic [7:0] F_IDLE  = 8'b1100_0000;
    localparam logic [7:0] F_HZ    = 8'b0000_1000;
    localparam logic [7:0] F_BR    = 8'b1110_0100;
    localparam logic [7:0] F_JP    = 8'b1101_0100;
    localparam logic [7:0] F_MDW   = 8'b0000_0010;
    localparam logic [7:0] F_IDLEE = 8'b1100_0001;
    localparam logic [7:0] F_HLTE  = 8'b0000_1001;
    localparam logic [7:0] F_HLTDE = 8'b0000_1011;

    typedef struct {
        string       name;
        logic [7:0]  flags;
        logic [31:0] scnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [7:0] got;
            e   = sb.pop_front();
            got = {IFWrite, IDWrite, Branch, Jump, ID_flush, IF_flush, busy, md_err};
            n_cmp++;
            if (got !== e.flags || stall_cnt !== e.scnt) begin
                n_bad++;
                $display("FAIL %s: got flags=%b stall_cnt=%0d, expected flags=%b stall_cnt=%0d",
                         e.name, got, stall_cnt, e.flags, e.scnt);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 0; ex_memread = 0;
        branch_taken = 0; jump = 0; md_start = 0; md_done = 0; halt = 0;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] fl, input logic [31:0] sc);
        exp_t e;
        e.name = nm; e.flags = fl; e.scnt = sc;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        nxt(); expect_out("reset_a", F_RST, 0);
        nxt(); expect_out("reset_b", F_RST, 0);
        // boot: exactly four fetch-held cycles after release
        nxt(); reset = 1'b1; expect_out("boot1", F_RST, 0);
        nxt(); expect_out("boot2", F_RST, 0);
        nxt(); expect_out("boot3", F_RST, 0);
        nxt(); expect_out("boot4", F_RST, 0);
        nxt(); expect_out("run_first", F_IDLE, 0);

        nxt(); ex_memread = 1; ex_rt = 5; id_rs = 5; expect_out("hz_rs", F_HZ, 0);
        nxt(); expect_out("after_hz_rs", F_IDLE, 1);
        nxt(); ex_memread = 1; ex_rt = 0; id_rs = 0; expect_out("hz_r0", F_IDLE, 1);
        nxt(); ex_memread = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 1; id_rs = 3;
               expect_out("hz_rt", F_HZ, 1);
        nxt(); ex_memread = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 0; id_rs = 3;
               expect_out("no_hz_rt_unused", F_IDLE, 2);

        nxt(); ex_memread = 1; ex_rt = 5; id_rs = 5; branch_taken = 1;
               expect_out("hz_plus_branch", F_HZ, 2);
        nxt(); branch_taken = 1; expect_out("branch_after_hz", F_BR, 3);
        nxt(); branch_taken = 1; jump = 1; expect_out("branch_and_jump", F_BR, 3);
        nxt(); jump = 1; expect_out("jump_only", F_JP, 3);
        nxt(); expect_out("idle_pre_md", F_IDLE, 3);

        nxt(); md_start = 1; expect_out("md_start_cycle", F_IDLE, 3);
        for (int k = 1; k <= 10; k++) begin
            nxt();
            if (k == 5) md_start = 1;
            if (k == 10) md_done = 1;
            expect_out($sformatf("md_wait_%0d", k), F_MDW, 32'(2 + k));
        end
        nxt(); expect_out("run_after_md_done", F_IDLE, 13);

        nxt(); md_start = 1; expect_out("md_start_to", F_IDLE, 13);
        for (int k = 1; k <= 64; k++) begin
            nxt();
            expect_out($sformatf("md_to_%0d", k), F_MDW, 32'(12 + k));
        end
        nxt(); expect_out("run_after_timeout", F_IDLEE, 77);

        nxt(); halt = 1; expect_out("halt_cycle", F_HLTE, 77);
        nxt(); expect_out("halted_1", F_HLTDE, 78);
        nxt(); branch_taken = 1; md_start = 1; expect_out("halted_2", F_HLTDE, 78);
        nxt(); expect_out("halted_3", F_HLTDE, 78);

        nxt(); reset = 1'b0; expect_out("reset_again", F_RST, 0);
        nxt(); reset = 1'b1; expect_out("reboot1", F_RST, 0);
        nxt(); expect_out("reboot2", F_RST, 0);
        nxt(); expect_out("reboot3", F_RST, 0);
        nxt(); expect_out("reboot4", F_RST, 0);
        nxt(); expect_out("rerun", F_IDLE, 0);

        // mid-MD_WAIT reset must drop back to BOOT with counters cleared
        nxt(); ex_memread = 1; ex_rt = 9; id_rs = 9; md_start = 1;
               expect_out("hz_with_md_start", F_HZ, 0);
        nxt(); expect_out("md_wait_after_hz", F_MDW, 1);
        nxt(); expect_out("md_wait_b", F_MDW, 2);
        nxt(); reset = 1'b0; expect_out("reset_in_md_wait", F_RST, 0);
        nxt(); reset = 1'b1; expect_out("boot_after_md_reset", F_RST, 0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
